// File: rtl/pw_tile_scheduler.sv
// Pointwise-conv tile sequencer: per pixel, seeds the MAC (clear or psum reload),
// streams k activations, then writes back the partial sum or hands off to the quantizer.
module pw_tile_scheduler #(
    parameter int PIXEL_TILE_SIZE = 128,
    parameter int ACT_AW          = 13
) (
    input  logic                CLK,
    input  logic                RESETn,

    input  logic                start,
    input  logic [7:0]          cfg_n_pix,
    input  logic [6:0]          cfg_k_len,
    input  logic                cfg_first_k,
    input  logic                cfg_last_k,

    output logic                busy,
    output logic                done,

    output logic                act_rd_en,
    output logic [ACT_AW-1:0]   act_rd_addr,
    input  logic signed [7:0]   act_rd_data,

    output logic [7:0]          t_in_tile,
    output logic                psum_do_read,
    input  logic                psum_rd_valid,
    input  logic [1023:0]       psum_rd_data,
    output logic                psum_do_write,
    output logic [1023:0]       psum_wr_data,

    output logic                mac_clear_pulse,
    output logic                mac_load_pulse,
    output logic [1023:0]       mac_load_data,
    output logic                mac_step_en,
    output logic signed [7:0]   mac_act_k,
    output logic [5:0]          mac_k,
    input  logic [1023:0]       acc_out,

    output logic                q_en,
    input  logic                q_valid
);

    localparam logic [7:0] NPIX_MAX = 8'(PIXEL_TILE_SIZE);
    localparam logic [6:0] KLEN_MAX = 7'd64;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_RD,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_QUANT,
        S_WAIT_Q,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [7:0]          n_pix_q;
    logic [6:0]          k_len_q;
    logic                first_k_q;
    logic                last_k_q;
    logic [6:0]          p_q;
    logic [5:0]          k_q;
    logic                drain_q;

    logic                busy_q;
    logic                done_q;
    logic                act_rd_en_q;
    logic [ACT_AW-1:0]   act_rd_addr_q;
    logic                clear_q;
    logic                load_q;
    logic                rd_q;
    logic                wr_q;
    logic                q_en_q;
    logic                step_q;
    logic [5:0]          mac_k_q;
    logic [1023:0]       load_data_q;

    logic [7:0]          n_pix_clamp;
    logic [6:0]          k_len_clamp;
    logic                last_pix;
    logic                last_k_step;
    logic [ACT_AW-1:0]   addr_first;
    logic [ACT_AW-1:0]   addr_next;

    assign n_pix_clamp = (cfg_n_pix > NPIX_MAX) ? NPIX_MAX : cfg_n_pix;
    assign k_len_clamp = (cfg_k_len > KLEN_MAX) ? KLEN_MAX : cfg_k_len;
    assign last_pix    = ({1'b0, p_q} == (n_pix_q - 8'd1));
    assign last_k_step = ({1'b0, k_q} == (k_len_q - 7'd1));
    assign addr_first  = ACT_AW'({p_q, 6'd0});
    assign addr_next   = ACT_AW'({p_q, k_q + 6'd1});

    // Strobes default low every cycle and are set together with the state they belong to,
    // so each one lines up exactly with its state and stays glitch-free.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= S_IDLE;
            n_pix_q       <= '0;
            k_len_q       <= '0;
            first_k_q     <= 1'b0;
            last_k_q      <= 1'b0;
            p_q           <= '0;
            k_q           <= '0;
            drain_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            act_rd_en_q   <= 1'b0;
            act_rd_addr_q <= '0;
            clear_q       <= 1'b0;
            load_q        <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            q_en_q        <= 1'b0;
            step_q        <= 1'b0;
            mac_k_q       <= '0;
            load_data_q   <= '0;
        end else begin
            clear_q       <= 1'b0;
            load_q        <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            q_en_q        <= 1'b0;
            done_q        <= 1'b0;
            act_rd_en_q   <= 1'b0;
            act_rd_addr_q <= '0;
            step_q        <= act_rd_en_q;
            mac_k_q       <= k_q;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_pix_q   <= n_pix_clamp;
                        k_len_q   <= k_len_clamp;
                        first_k_q <= cfg_first_k;
                        last_k_q  <= cfg_last_k;
                        p_q       <= '0;
                        if (n_pix_clamp == 8'd0 || k_len_clamp == 7'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_INIT;
                            busy_q  <= 1'b1;
                            clear_q <= cfg_first_k;
                            rd_q    <= ~cfg_first_k;
                        end
                    end
                end

                S_INIT: begin
                    if (first_k_q) begin
                        state_q       <= S_ISSUE;
                        k_q           <= '0;
                        act_rd_en_q   <= 1'b1;
                        act_rd_addr_q <= addr_first;
                    end else begin
                        state_q <= S_WAIT_RD;
                    end
                end

                S_WAIT_RD: begin
                    if (psum_rd_valid) begin
                        load_data_q <= psum_rd_data;
                        load_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    state_q       <= S_ISSUE;
                    k_q           <= '0;
                    act_rd_en_q   <= 1'b1;
                    act_rd_addr_q <= addr_first;
                end

                S_ISSUE: begin
                    if (last_k_step) begin
                        state_q <= S_DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        k_q           <= k_q + 6'd1;
                        act_rd_en_q   <= 1'b1;
                        act_rd_addr_q <= addr_next;
                    end
                end

                // First drain cycle retires the last MAC step, second lets acc_out settle.
                S_DRAIN: begin
                    if (drain_q) begin
                        if (last_k_q) begin
                            state_q <= S_QUANT;
                            q_en_q  <= 1'b1;
                        end else begin
                            state_q <= S_WRITE;
                            wr_q    <= 1'b1;
                        end
                    end else begin
                        drain_q <= 1'b1;
                    end
                end

                S_QUANT: begin
                    state_q <= S_WAIT_Q;
                end

                S_WRITE, S_WAIT_Q: begin
                    if (state_q == S_WRITE || q_valid) begin
                        if (last_pix) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            p_q     <= p_q + 7'd1;
                            state_q <= S_INIT;
                            clear_q <= first_k_q;
                            rd_q    <= ~first_k_q;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign act_rd_en       = act_rd_en_q;
    assign act_rd_addr     = act_rd_addr_q;
    assign t_in_tile       = {1'b0, p_q};
    assign psum_do_read    = rd_q;
    assign psum_do_write   = wr_q;
    assign psum_wr_data    = wr_q ? acc_out : '0;
    assign mac_clear_pulse = clear_q;
    assign mac_load_pulse  = load_q;
    assign mac_load_data   = load_data_q;
    assign mac_step_en     = step_q;
    assign mac_act_k       = step_q ? act_rd_data : 8'sd0;
    assign mac_k           = mac_k_q;
    assign q_en            = q_en_q;

endmodule

// File: tb/tb_pw_tile_scheduler.sv
// Bench for pw_tile_scheduler: table-driven jobs plus random jobs, checked against
// an arithmetic timing model of the per-pixel schedule and a memory/response model.
module tb_pw_tile_scheduler;

    localparam int PTS = 128;
    localparam int AW  = 13;

    logic                CLK = 1'b0;
    logic                RESETn;
    logic                start;
    logic [7:0]          cfg_n_pix;
    logic [6:0]          cfg_k_len;
    logic                cfg_first_k;
    logic                cfg_last_k;
    logic                busy;
    logic                done;
    logic                act_rd_en;
    logic [AW-1:0]       act_rd_addr;
    logic signed [7:0]   act_rd_data;
    logic [7:0]          t_in_tile;
    logic                psum_do_read;
    logic                psum_rd_valid;
    logic [1023:0]       psum_rd_data;
    logic                psum_do_write;
    logic [1023:0]       psum_wr_data;
    logic                mac_clear_pulse;
    logic                mac_load_pulse;
    logic [1023:0]       mac_load_data;
    logic                mac_step_en;
    logic signed [7:0]   mac_act_k;
    logic [5:0]          mac_k;
    logic [1023:0]       acc_out;
    logic                q_en;
    logic                q_valid;

    always #5 CLK = ~CLK;

    pw_tile_scheduler #(.PIXEL_TILE_SIZE(PTS), .ACT_AW(AW)) dut (
        .CLK(CLK), .RESETn(RESETn), .start(start),
        .cfg_n_pix(cfg_n_pix), .cfg_k_len(cfg_k_len),
        .cfg_first_k(cfg_first_k), .cfg_last_k(cfg_last_k),
        .busy(busy), .done(done),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .t_in_tile(t_in_tile), .psum_do_read(psum_do_read), .psum_rd_valid(psum_rd_valid),
        .psum_rd_data(psum_rd_data), .psum_do_write(psum_do_write), .psum_wr_data(psum_wr_data),
        .mac_clear_pulse(mac_clear_pulse), .mac_load_pulse(mac_load_pulse),
        .mac_load_data(mac_load_data), .mac_step_en(mac_step_en), .mac_act_k(mac_act_k),
        .mac_k(mac_k), .acc_out(acc_out), .q_en(q_en), .q_valid(q_valid)
    );

    typedef struct {
        int n; int k; bit fk; bit lk;
        int rd_lat; int q_lat; int restart_at;
        int exp_done; int exp_wr; int exp_q;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [7:0]    act_mem [0:8191];
    int            rd_lat = 1;
    int            q_lat = 1;
    bit            noise_en = 1'b1;
    logic [1023:0] exp_load_word;

    bit            job_active = 1'b0;
    int            t0 = 0;
    int            cur_done = 0;
    int            busy_err, onehot_err, pix_cnt;
    int            got_clear[$], got_read[$], got_load[$], got_write[$], got_q[$], got_done[$];
    logic [12:0]   exp_addr[$], issued[$];

    function automatic logic [1023:0] rnd_wide();
        logic [1023:0] w;
        for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic bit outs_nz();
        return (|{busy, done, act_rd_en, act_rd_addr, t_in_tile, psum_do_read, psum_do_write,
                  mac_clear_pulse, mac_load_pulse, mac_step_en, mac_act_k, mac_k, q_en})
               || (|psum_wr_data) || (|mac_load_data);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input int got[$], input int exp[$]);
        bit ok;
        vectors++;
        ok = (got.size() == exp.size());
        if (ok) foreach (got[i]) if (got[i] != exp[i]) ok = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d events (first at %0d), expected %0d events (first at %0d)",
                     name, got.size(), (got.size() > 0) ? got[0] : -1,
                     exp.size(), (exp.size() > 0) ? exp[0] : -1);
        end
    endtask

    // Environment: activation RAM with 1-cycle latency, psum/quant responders with
    // programmable latency plus stray valids when nothing is outstanding.
    initial begin
        int rd_cnt, q_cnt;
        bit prev_en;
        logic [12:0] prev_addr;
        rd_cnt = 0; q_cnt = 0; prev_en = 1'b0; prev_addr = '0;
        act_rd_data = '0; psum_rd_valid = 1'b0; psum_rd_data = '0;
        q_valid = 1'b0; acc_out = '0; exp_load_word = '0;
        forever begin
            @(posedge CLK); #1;
            act_rd_data = prev_en ? act_mem[prev_addr] : 8'($urandom);
            prev_en   = act_rd_en;
            prev_addr = act_rd_addr;
            acc_out   = rnd_wide();
            psum_rd_valid = 1'b0;
            psum_rd_data  = rnd_wide();
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    psum_rd_valid = 1'b1;
                    exp_load_word = psum_rd_data;
                end
            end else if (noise_en && !psum_do_read && $urandom_range(3) == 0) begin
                psum_rd_valid = 1'b1;
            end
            if (psum_do_read) rd_cnt = rd_lat;
            q_valid = 1'b0;
            if (q_cnt > 0) begin
                q_cnt--;
                if (q_cnt == 0) q_valid = 1'b1;
            end else if (noise_en && !q_en && $urandom_range(3) == 0) begin
                q_valid = 1'b1;
            end
            if (q_en) q_cnt = q_lat;
        end
    end

    always @(negedge CLK) begin : mon
        int rel;
        logic [12:0] a;
        if (job_active) begin
            rel = cyc - t0;
            if (busy !== ((rel >= 1) && (rel < cur_done))) busy_err++;
            if ($countones({mac_clear_pulse, mac_load_pulse, psum_do_read, psum_do_write, q_en}) > 1)
                onehot_err++;
            if (mac_clear_pulse) got_clear.push_back(rel);
            if (psum_do_read)    got_read.push_back(rel);
            if (mac_load_pulse)  got_load.push_back(rel);
            if (psum_do_write)   got_write.push_back(rel);
            if (q_en)            got_q.push_back(rel);
            if (done)            got_done.push_back(rel);
            if (mac_load_pulse) begin
                vectors++;
                if (mac_load_data !== exp_load_word) begin
                    miscompares++;
                    $display("FAIL load_data @cyc %0d: got low %h, expected low %h",
                             cyc, mac_load_data[63:0], exp_load_word[63:0]);
                end
            end
            if (psum_do_write) begin
                vectors++;
                if (psum_wr_data !== acc_out) begin
                    miscompares++;
                    $display("FAIL wr_data @cyc %0d: got low %h, expected low %h",
                             cyc, psum_wr_data[63:0], acc_out[63:0]);
                end
            end
            if (psum_do_write || q_en) begin
                chk("t_in_tile", t_in_tile, pix_cnt);
                pix_cnt++;
            end
            if (act_rd_en) begin
                if (exp_addr.size() == 0) begin
                    chk("extra_act_rd", 1, 0);
                end else begin
                    a = exp_addr.pop_front();
                    chk("act_addr", act_rd_addr, a);
                end
                issued.push_back(act_rd_addr);
            end
            if (mac_step_en) begin
                if (issued.size() == 0) begin
                    chk("extra_step", 1, 0);
                end else begin
                    a = issued.pop_front();
                    chk("mac_act_k", {mac_act_k}, act_mem[a]);
                    chk("mac_k", mac_k, a[5:0]);
                end
            end
        end
    end

    task automatic run_job(input vec_t v);
        int nc, kc, L, dn, s;
        int e_clear[$], e_read[$], e_load[$], e_write[$], e_q[$], e_done[$];
        nc = (v.n > PTS) ? PTS : v.n;
        kc = (v.k > 64) ? 64 : v.k;
        got_clear.delete(); got_read.delete(); got_load.delete();
        got_write.delete(); got_q.delete(); got_done.delete();
        exp_addr.delete(); issued.delete();
        busy_err = 0; onehot_err = 0; pix_cnt = 0;
        dn = 1;
        if (nc > 0 && kc > 0) begin
            L = 1 + (v.fk ? 0 : v.rd_lat + 1) + kc + 2 + (v.lk ? 1 + v.q_lat : 1);
            for (int i = 0; i < nc; i++) begin
                s = 1 + i * L;
                if (v.fk) e_clear.push_back(s);
                else begin
                    e_read.push_back(s);
                    e_load.push_back(s + 1 + v.rd_lat);
                end
                if (v.lk) e_q.push_back(s + L - 1 - v.q_lat);
                else      e_write.push_back(s + L - 1);
                for (int k = 0; k < kc; k++) exp_addr.push_back({7'(i), 6'(k)});
            end
            dn = 1 + nc * L;
        end
        cur_done = (v.exp_done >= 0) ? v.exp_done : dn;
        e_done.push_back(cur_done);
        rd_lat = v.rd_lat;
        q_lat  = v.q_lat;

        @(negedge CLK);
        cfg_n_pix = 8'(v.n); cfg_k_len = 7'(v.k);
        cfg_first_k = v.fk; cfg_last_k = v.lk;
        start = 1'b1;
        t0 = cyc;
        job_active = 1'b1;
        for (int r = 1; r <= cur_done + 4; r++) begin
            @(negedge CLK);
            start = (r == v.restart_at);
            cfg_n_pix = 8'($urandom); cfg_k_len = 7'($urandom);
            cfg_first_k = 1'($urandom); cfg_last_k = 1'($urandom);
        end
        start = 1'b0;
        job_active = 1'b0;

        chk_q("clear_cycles", got_clear, e_clear);
        chk_q("read_cycles",  got_read,  e_read);
        chk_q("load_cycles",  got_load,  e_load);
        chk_q("write_cycles", got_write, e_write);
        chk_q("qen_cycles",   got_q,     e_q);
        chk_q("done_cycles",  got_done,  e_done);
        chk("strobe_onehot", onehot_err, 0);
        chk("busy_window", busy_err, 0);
        chk("act_addrs_left", exp_addr.size(), 0);
        chk("steps_left", issued.size(), 0);
        if (v.exp_wr >= 0) chk("n_writes", got_write.size(), v.exp_wr);
        if (v.exp_q >= 0)  chk("n_qen", got_q.size(), v.exp_q);
    endtask

    initial begin
        vec_t tbl[13];
        vec_t v;
        bit seen;

        tbl[0]  = '{2,   4,   1, 0, 1, 1, -1, 17,   2,   0};
        tbl[1]  = '{1,   3,   0, 0, 3, 1, -1, 12,   1,   0};
        tbl[2]  = '{1,   1,   1, 1, 1, 5, -1, 11,   0,   1};
        tbl[3]  = '{0,   0,   1, 0, 1, 1, -1, 1,    0,   0};
        tbl[4]  = '{0,   5,   0, 1, 1, 1, -1, 1,    0,   0};
        tbl[5]  = '{3,   0,   1, 1, 1, 1, -1, 1,    0,   0};
        tbl[6]  = '{200, 1,   1, 0, 1, 1, -1, 641,  128, 0};
        tbl[7]  = '{1,   100, 1, 0, 1, 1, -1, 69,   1,   0};
        tbl[8]  = '{2,   2,   0, 1, 1, 1, -1, 19,   0,   2};
        tbl[9]  = '{2,   4,   1, 0, 1, 1, 5,  17,   2,   0};
        tbl[10] = '{1,   1,   1, 0, 1, 1, 6,  6,    1,   0};
        tbl[11] = '{128, 2,   0, 0, 2, 1, -1, 1153, 128, 0};
        tbl[12] = '{1,   64,  0, 1, 2, 3, -1, 75,   0,   1};

        foreach (act_mem[i]) act_mem[i] = 8'($urandom);
        RESETn = 1'b0; start = 1'b0;
        cfg_n_pix = '0; cfg_k_len = '0; cfg_first_k = 1'b0; cfg_last_k = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", outs_nz(), 0);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", outs_nz(), 0);

        foreach (tbl[i]) run_job(tbl[i]);

        for (int j = 0; j < 24; j++) begin
            if ($urandom_range(7) == 0) begin
                v.n = $urandom_range(255, 129);
                v.k = $urandom_range(1, 0);
            end else begin
                v.n = $urandom_range(10, 0);
                v.k = $urandom_range(70, 0);
            end
            v.fk = 1'($urandom); v.lk = 1'($urandom);
            v.rd_lat = $urandom_range(4, 1);
            v.q_lat  = $urandom_range(4, 1);
            v.restart_at = ($urandom_range(1) == 0) ? $urandom_range(20, 1) : -1;
            v.exp_done = -1; v.exp_wr = -1; v.exp_q = -1;
            run_job(v);
        end

        // Asynchronous reset in the middle of ISSUE.
        @(negedge CLK);
        cfg_n_pix = 8'd2; cfg_k_len = 7'd4; cfg_first_k = 1'b1; cfg_last_k = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (act_rd_en) seen = 1'b1;
            else @(negedge CLK);
        end
        chk("reached_issue", seen, 1);
        #2 RESETn = 1'b0;
        #1 chk("async_reset_outputs", outs_nz(), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("post_reset_idle", |{busy, done, act_rd_en, mac_step_en, mac_clear_pulse,
                                     mac_load_pulse, psum_do_read, psum_do_write, q_en}, 0);
        end

        v = '{3, 5, 0, 1, 2, 2, 4, -1, 0, 3};
        run_job(v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
